// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR generator/checker pair.
//   chk_state_e    : checker FSM encoding (SEARCH, VERIFY, LOCKED)
//   DEFAULT_TAPS_3 : x^3+x^2+1 tap mask for the 3-bit link
//   lfsr_step()    : Fibonacci shift-left step, shared by generator and checker
package lfsr_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_e;

  localparam logic [2:0] DEFAULT_TAPS_3 = 3'b110;

  // Widest LFSR the shared step function supports; callers zero-extend.
  localparam int unsigned LFSR_MAX_W = 32;

  // next(s) = {s[w-2:0], ^(s & taps)}, result masked to the low w bits.
  // Upper bits of s/taps must be zero so the feedback sees only w bits.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_step(
    input logic [LFSR_MAX_W-1:0] s,
    input logic [LFSR_MAX_W-1:0] taps,
    input int unsigned           w
  );
    logic [LFSR_MAX_W-1:0] nxt;
    nxt = {s[LFSR_MAX_W-2:0], ^(s & taps)};
    for (int unsigned i = 0; i < LFSR_MAX_W; i++) begin
      if (i >= w) begin
        nxt[i] = 1'b0;
      end else begin
        nxt[i] = nxt[i];
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/lfsr_next_state.sv
// Combinational one-step LFSR advance.
//   state_i : current LFSR word
//   taps_i  : tap mask
//   next_o  : next(state_i) under taps_i
module lfsr_next_state
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] state_i,
  input  logic [WIDTH-1:0] taps_i,
  output logic [WIDTH-1:0] next_o
);

  localparam int unsigned W_C = WIDTH;

  logic [LFSR_MAX_W-1:0] wide_next_s;
  // Bits above WIDTH are always zero; reduced here only so they are consumed.
  logic                  unused_next_s;

  assign wide_next_s   = lfsr_step(LFSR_MAX_W'(state_i), LFSR_MAX_W'(taps_i), W_C);
  assign next_o        = wide_next_s[WIDTH-1:0];
  assign unused_next_s = ^wide_next_s;

endmodule

// File: rtl/lfsr_checker.sv
// Receive-side LFSR checker: self-synchronises on incoming words, locks after
// LOCK_COUNT consecutive correct predictions, then flywheels and flags errors.
// Ports:
//   clk, reset          : rising-edge clock, async active-high reset
//   enable              : sample-valid qualifier (state held when low)
//   use_config_lfsr     : 0 = DEFAULT_TAPS, 1 = config_taps
//   config_taps         : runtime tap mask
//   lfsr_in             : word from the generator
//   err_clear           : (only with LFSR_CHK_ERR_CLEAR_EN) zero err_count
//   locked, error       : lock status, one-cycle mismatch pulse while locked
//   err_count           : saturating count of locked mismatches
// Build option: define LFSR_CHK_ERR_CLEAR_EN to add the err_clear input.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int               WIDTH         = 3,
  parameter logic [WIDTH-1:0] DEFAULT_TAPS  = WIDTH'(DEFAULT_TAPS_3),
  parameter int               LOCK_COUNT    = 4,
  parameter int               UNLOCK_COUNT  = 3,
  parameter int               ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     use_config_lfsr,
  input  logic [WIDTH-1:0]         config_taps,
  input  logic [WIDTH-1:0]         lfsr_in,
`ifdef LFSR_CHK_ERR_CLEAR_EN
  input  logic                     err_clear,
`endif
  output logic                     locked,
  output logic                     error,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  localparam logic [3:0]             LOCK_C   = 4'(LOCK_COUNT);
  localparam logic [3:0]             UNLOCK_C = 4'(UNLOCK_COUNT);
  localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX_C = {ERR_CNT_WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]       ZERO_W_C = {WIDTH{1'b0}};

  chk_state_e               state_q, state_d;
  logic [WIDTH-1:0]         pred_q, pred_d;
  logic [3:0]               match_q, match_d;
  logic [3:0]               miss_q, miss_d;
  logic                     locked_q, locked_d;
  logic                     error_q, error_d;
  logic [ERR_CNT_WIDTH-1:0] err_q, err_d;
  logic [WIDTH:0]           cfg_q;

  logic [WIDTH-1:0] taps_s;
  logic [WIDTH-1:0] seed_next_s;
  logic [WIDTH-1:0] fly_next_s;
  logic             tap_change_s;
  logic             clr_s;

  assign taps_s       = use_config_lfsr ? config_taps : DEFAULT_TAPS;
  assign tap_change_s = ({use_config_lfsr, config_taps} != cfg_q);

`ifdef LFSR_CHK_ERR_CLEAR_EN
  assign clr_s = err_clear;
`else
  assign clr_s = 1'b0;
`endif

  // Seed path: prediction derived from the received word.
  lfsr_next_state #(.WIDTH(WIDTH)) u_seed_next (
    .state_i (lfsr_in),
    .taps_i  (taps_s),
    .next_o  (seed_next_s)
  );

  // Flywheel path: prediction derived from the previous prediction.
  lfsr_next_state #(.WIDTH(WIDTH)) u_fly_next (
    .state_i (pred_q),
    .taps_i  (taps_s),
    .next_o  (fly_next_s)
  );

  // Next-state logic for the FSM, prediction, counters and outputs.
  always_comb begin
    state_d  = state_q;
    pred_d   = pred_q;
    match_d  = match_q;
    miss_d   = miss_q;
    locked_d = locked_q;
    error_d  = 1'b0;
    err_d    = err_q;

    if (tap_change_s) begin
      // Polynomial changed under us: drop the sample and resynchronise.
      state_d  = SEARCH;
      locked_d = 1'b0;
      match_d  = 4'd0;
      miss_d   = 4'd0;
    end else if (enable) begin
      case (state_q)
        SEARCH: begin
          if (lfsr_in != ZERO_W_C) begin
            pred_d  = seed_next_s;
            match_d = 4'd0;
            state_d = VERIFY;
          end else begin
            state_d = SEARCH;
          end
        end
        VERIFY: begin
          if (lfsr_in == pred_q) begin
            match_d = match_q + 4'd1;
            pred_d  = seed_next_s;
            if ((match_q + 4'd1) == LOCK_C) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
              miss_d   = 4'd0;
            end else begin
              state_d = VERIFY;
            end
          end else if (lfsr_in != ZERO_W_C) begin
            pred_d  = seed_next_s;
            match_d = 4'd0;
          end else begin
            state_d = SEARCH;
            match_d = 4'd0;
          end
        end
        LOCKED: begin
          pred_d = fly_next_s;
          if (lfsr_in == pred_q) begin
            miss_d = 4'd0;
          end else begin
            error_d = 1'b1;
            if (err_q != ERR_MAX_C) begin
              err_d = err_q + ERR_CNT_WIDTH'(1'b1);
            end else begin
              err_d = err_q;
            end
            if ((miss_q + 4'd1) == UNLOCK_C) begin
              state_d  = SEARCH;
              locked_d = 1'b0;
              miss_d   = 4'd0;
              match_d  = 4'd0;
            end else begin
              miss_d = miss_q + 4'd1;
            end
          end
        end
        default: begin
          state_d  = SEARCH;
          locked_d = 1'b0;
          match_d  = 4'd0;
          miss_d   = 4'd0;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    // Clear wins over an increment in the same cycle.
    if (clr_s) begin
      err_d = {ERR_CNT_WIDTH{1'b0}};
    end else begin
      err_d = err_d;
    end
  end

  // State, prediction, counters, tap snapshot and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= SEARCH;
      pred_q   <= ZERO_W_C;
      match_q  <= 4'd0;
      miss_q   <= 4'd0;
      locked_q <= 1'b0;
      error_q  <= 1'b0;
      err_q    <= {ERR_CNT_WIDTH{1'b0}};
      cfg_q    <= {(WIDTH+1){1'b0}};
    end else begin
      state_q  <= state_d;
      pred_q   <= pred_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
      locked_q <= locked_d;
      error_q  <= error_d;
      err_q    <= err_d;
      cfg_q    <= {use_config_lfsr, config_taps};
    end
  end

  assign locked    = locked_q;
  assign error     = error_q;
  assign err_count = err_q;

endmodule

// File: doc/lfsr_checker.md
Name: lfsr_checker

Overview:
- Receive end of the LFSR link: samples the parallel word produced by the LFSR generator each enabled cycle and checks it against a locally predicted sequence.
- Self-synchronises from the incoming data, declares lock after a run of correct words, then flags mismatches and counts errors.
- Uses the same tap selection as the generator (static default taps or runtime `config_taps`), so it is checked against whichever polynomial the generator is running.

Parameters:
- WIDTH, 3: LFSR word width, ≥2.
- DEFAULT_TAPS, 3'b110: static tap mask used when use_config_lfsr=0 (x^3+x^2+1 at WIDTH=3).
- LOCK_COUNT, 4: consecutive matches needed to declare lock, 1..15.
- UNLOCK_COUNT, 3: consecutive mismatches while locked that drop lock, 1..15.
- ERR_CNT_WIDTH, 16: width of the saturating error counter.

Ports:
- clk, input, 1: single clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- enable, input, 1: sample-valid qualifier; when 0, state is held.
- use_config_lfsr, input, 1: 0 selects DEFAULT_TAPS, 1 selects config_taps.
- config_taps, input, WIDTH: runtime tap mask.
- lfsr_in, input, WIDTH: word from the generator.
- locked, output, 1: checker is in LOCKED state.
- error, output, 1: one-cycle pulse on a mismatch while locked.
- err_count, output, ERR_CNT_WIDTH: saturating count of locked mismatches.

Behaviour:
- Step function next(s) = {s[WIDTH-2:0], ^(s & taps)}, Fibonacci, shift left; taps is the effective mask selected by use_config_lfsr.
- Reset values: locked=0, error=0, err_count=0, FSM=SEARCH, predicted=0, match and miss counters=0.
- All outputs are registered. A result is visible the cycle after the edge that sampled lfsr_in.
- enable=0: FSM, predicted and counters hold; error=0.
- SEARCH:
  - lfsr_in≠0: predicted<=next(lfsr_in), match_cnt<=0, go to VERIFY.
  - lfsr_in=0 (illegal lockup word): stay in SEARCH.
- VERIFY:
  - lfsr_in==predicted: match_cnt++, predicted<=next(lfsr_in). When match_cnt reaches LOCK_COUNT, go to LOCKED and set locked=1 on that same edge.
  - Mismatch with lfsr_in≠0: reseed predicted<=next(lfsr_in), match_cnt<=0, stay in VERIFY.
  - Mismatch with lfsr_in=0: go to SEARCH.
- LOCKED (flywheel):
  - predicted<=next(predicted) every enabled cycle; no reseeding.
  - Match: miss_cnt<=0, error=0.
  - Mismatch: error=1 for one cycle, err_count++ (holds at all-ones, no wrap), miss_cnt++.
  - If miss_cnt reaches UNLOCK_COUNT: go to SEARCH and set locked=0 on that edge. The error pulse and count increment for that word still occur.
- Tap change:
  - {use_config_lfsr, config_taps} is registered each cycle.
  - If the current value differs from the registered value, the next edge forces SEARCH, locked=0 and counters cleared, regardless of enable.
  - That cycle's sample is discarded and err_count is unchanged.
- Reset mid-operation: returns all state to reset values immediately (asynchronous).
- error is never asserted outside LOCKED.

Optional Feature:
- Macro LFSR_CHK_ERR_CLEAR_EN.
- Defined: adds input port err_clear (1 bit). err_clear=1 synchronously zeroes err_count on the next edge and takes priority over an increment in the same cycle. FSM is unaffected.
- Undefined: no err_clear port; err_count clears only on reset.

Decomposition:
- Shared package lfsr_pkg holds:
  - FSM state typedef: SEARCH=2'd0, VERIFY=2'd1, LOCKED=2'd2.
  - DEFAULT_TAPS_3 constant (3'b110).
  - The step function, so the generator and checker share a single definition.
- One natural combinational sub-module, lfsr_next_state(WIDTH): inputs state and taps, output next. Instantiated twice, once for the seed path (next(lfsr_in)) and once for the flywheel path (next(predicted)).

Test Plan:
Reference sequences at WIDTH=3: taps 110 gives 001,010,101,011,111,110,100 (period 7); taps 101 gives 001,011,111,110,101,010,100.
- Lock: default taps, enable=1, feed 001,010,101,011,111 → locked=1 after the 5th sample; error stays 0 and err_count=0.
- Single error: once locked, send 000 in place of 110, then continue with 100,001 → error pulses exactly one cycle, err_count=1, locked stays 1, following words match.
- Unlock: once locked, send 3 consecutive wrong words → err_count=3, locked=0 after the 3rd. Then feed 7 correct words → relock, err_count stays 3.
- Enable gaps and zero input: enable=0 for 5 cycles mid-lock with garbage on lfsr_in → no error, state held. Feed 000 repeatedly in SEARCH → stays in SEARCH, locked=0.
- Tap switch: locked on taps 110, set use_config_lfsr=1, config_taps=101 → locked=0 on the next edge. Then feed 001,011,111,110,101 → relock with no error pulses.
- Reset and option: assert reset mid-LOCKED → locked=0, err_count=0 immediately. With LFSR_CHK_ERR_CLEAR_EN, assert err_clear in the same cycle as a mismatch → err_count=0.
